tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequencer for the TLB-management instructions TLBP, TLBR and TLBWI. A retiring instruction in the WB stage hands its TLB operation to this block, which then:
- drives the 16-entry TLB search, read and write ports in a fixed order;
- issues the update pulses that the CP0 register file uses to load Index, EntryHi and EntryLo0/1;
- requests a pipeline refetch from PC+4 after any operation that changes the translation context.

It sits between the WB stage, the CP0 register file and the TLB.

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries. The index width is 4 bits.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  WB presents a TLB operation.
- req_op  in  2  operation code: 2'b01 TLBP, 2'b10 TLBR, 2'b11 TLBWI, 2'b00 no-op.
- req_pc  in  32  PC of the TLB instruction.
- req_ready  out  1  the block can accept a request.
- c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index  in  32 each  current CP0 register values.
- s_vpn2  out  19  search VPN2.
- s_asid  out  8  search ASID.
- s_found  in  1  combinational search hit.
- s_index  in  4  combinational search hit index.
- r_index  out  4  TLB read index. The TLB read data goes directly to CP0.
- w_we  out  1  TLB write enable.
- w_index  out  4  TLB write index.
- w_vpn2  out  19  write field.
- w_asid  out  8  write field.
- w_g  out  1  write field.
- w_pfn0, w_pfn1  out  20 each  write fields.
- w_c0, w_c1  out  3 each  write fields.
- w_d0, w_d1, w_v0, w_v1  out  1 each  write fields.
- tlbp  out  1  one-cycle pulse: CP0 loads the Index P bit and the index.
- tlbp_found  out  1  search result, valid while tlbp=1.
- tlbp_index  out  4  search index, valid while tlbp=1.
- tlbr  out  1  one-cycle pulse: CP0 loads EntryHi/Lo from the TLB read port.
- refetch_valid  out  1  request to refetch from refetch_pc.
- refetch_pc  out  32  refetch address.
- refetch_ready  in  1  the front end accepts the refetch.
- busy  out  1  the block is not in IDLE. WB stalls any following mtc0 or TLB instruction while busy=1.

## Operation
States: IDLE, SRCH, PWB, READ, WRITE, REFETCH.

IDLE
- req_ready=1.
- On req_valid with req_op≠0, the block accepts the request and latches into snapshot registers:
  - op and req_pc;
  - entryhi[31:13] and entryhi[7:0];
  - lo0[25:0] and lo1[25:0];
  - index[3:0].
- Next state: TLBP→SRCH, TLBR→READ, TLBWI→WRITE.
- req_op=0 is ignored and the state is unchanged.

SRCH
- Drives s_vpn2 and s_asid from the snapshot.
- Registers s_found and s_index at the clock edge.
- Next state: PWB.

PWB
- tlbp=1, with tlbp_found and tlbp_index taken from the registered result.
- Next state: IDLE. There is no refetch.

READ
- r_index = snapshot index.
- tlbr=1.
- Next state: REFETCH.

WRITE
- w_we=1 and w_index = snapshot index.
- vpn2, asid, pfn, c, d and v fields come from the snapshot.
- w_g = lo0[0] & lo1[0].
- Next state: REFETCH.

REFETCH
- refetch_valid=1 and refetch_pc = snapshot pc + 4, modulo 2^32.
- Holds until refetch_ready=1, then goes to IDLE in the next cycle.

Output rules:
- All outputs other than req_ready and busy are zero outside their own state, including s_vpn2/s_asid, r_index and w_*.
- busy=1 in every non-IDLE state.

Snapshots:
- The snapshot is taken at acceptance.
- A change to a CP0 input after acceptance has no effect on the operation in flight.

## Timing
- Reset:
  - Asserting resetn=0 forces IDLE at any time, including mid-operation.
  - It clears every output and the snapshot to 0, so that no w_we, tlbp or tlbr pulse leaks out.
  - req_ready=1 while resetn=1 in IDLE.
- Latency from acceptance in cycle T:
  - TLBP: search in T+1, tlbp pulse in T+2, req_ready again in T+3.
  - TLBR: tlbr in T+1, refetch_valid from T+2.
  - TLBWI: w_we in T+1, refetch_valid from T+2.
- Each tlbp, tlbr and w_we pulse is exactly one cycle per operation.
- REFETCH with refetch_ready=1 in the cycle of entry completes in 1 cycle. Otherwise refetch_valid and refetch_pc stay stable until the handshake.
- req_valid outside IDLE is not accepted (req_ready=0). WB must hold the request until req_ready=1.
- Accepting back-to-back requests: a new request is accepted in the first IDLE cycle after completion. There is no overlap.
- The TLBWI write becomes visible in the TLB on the edge ending WRITE.

## Test plan
- Reset mid-operation: accept TLBWI, then pull resetn low in the WRITE cycle before the edge → w_we=0 after reset, state IDLE, refetch_valid=0, req_ready=1.
- TLBP hit: entryhi=0x0040_2005 and the TLB returns s_found=1, s_index=7 → s_vpn2=0x00201 and s_asid=0x05 at T+1; tlbp=1, tlbp_found=1, tlbp_index=7 at T+2; no refetch.
- TLBP miss: s_found=0 → tlbp=1 and tlbp_found=0 for one cycle.
- TLBR: index=3, req_pc=0xBFC0_0100 → r_index=3 and tlbr=1 at T+1; refetch_pc=0xBFC0_0104.
- TLBWI with G and wrap: index=0xF, lo0=0x0000_0047, lo1=0x0000_0046, req_pc=0xFFFF_FFFC, and c0_index changed after acceptance:
  - → w_we=1, w_index=0xF, w_g=0, w_pfn0=1, w_c0=0;
  - → the snapshot index is still used;
  - → refetch_pc=0x0000_0000.
- Refetch backpressure: refetch_ready held at 0 for 5 cycles → refetch_valid, refetch_pc and busy stable; a req_valid during this time is not accepted; IDLE one cycle after refetch_ready=1.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// Bundle of all non-clock signals of the TLB operation sequencer: WB request,
// CP0 register values and update pulses, TLB search/read/write ports, refetch.
interface tlb_op_ctrl_if #(
    parameter int unsigned IDXW = 4
);
    // WB request
    logic            req_valid;
    logic [1:0]      req_op;
    logic [31:0]     req_pc;
    logic            req_ready;

    // Current CP0 register values
    logic [31:0]     c0_entryhi;
    logic [31:0]     c0_entrylo0;
    logic [31:0]     c0_entrylo1;
    logic [31:0]     c0_index;

    // TLB search port
    logic [18:0]     s_vpn2;
    logic [7:0]      s_asid;
    logic            s_found;
    logic [IDXW-1:0] s_index;

    // TLB read port
    logic [IDXW-1:0] r_index;

    // TLB write port
    logic            w_we;
    logic [IDXW-1:0] w_index;
    logic [18:0]     w_vpn2;
    logic [7:0]      w_asid;
    logic            w_g;
    logic [19:0]     w_pfn0;
    logic [19:0]     w_pfn1;
    logic [2:0]      w_c0;
    logic [2:0]      w_c1;
    logic            w_d0;
    logic            w_d1;
    logic            w_v0;
    logic            w_v1;

    // CP0 update pulses
    logic            tlbp;
    logic            tlbp_found;
    logic [IDXW-1:0] tlbp_index;
    logic            tlbr;

    // Front-end refetch
    logic            refetch_valid;
    logic [31:0]     refetch_pc;
    logic            refetch_ready;

    logic            busy;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_pc,
        input  c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index,
        input  s_found, s_index, refetch_ready,
        output req_ready, s_vpn2, s_asid, r_index,
        output w_we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1,
        output w_c0, w_c1, w_d0, w_d1, w_v0, w_v1,
        output tlbp, tlbp_found, tlbp_index, tlbr,
        output refetch_valid, refetch_pc, busy
    );

    // Environment side (WB, CP0, TLB, front end)
    modport master (
        output req_valid, req_op, req_pc,
        output c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index,
        output s_found, s_index, refetch_ready,
        input  req_ready, s_vpn2, s_asid, r_index,
        input  w_we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1,
        input  w_c0, w_c1, w_d0, w_d1, w_v0, w_v1,
        input  tlbp, tlbp_found, tlbp_index, tlbr,
        input  refetch_valid, refetch_pc, busy
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB management sequencer for TLBP / TLBR / TLBWI. Accepts one operation from
// WB, snapshots the CP0 state, drives the TLB ports in a fixed order, pulses the
// CP0 update strobes and requests a refetch after context-changing operations.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic         clk,
    input  logic         resetn,
    tlb_op_ctrl_if.slave bus
);

    localparam int unsigned IdxW = $clog2(TLBNUM);

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpTlbp  = 2'b01,
        OpTlbr  = 2'b10,
        OpTlbwi = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StSrch,
        StPwb,
        StRead,
        StWrite,
        StRefetch
    } state_e;

    state_e            state_q, state_d;

    // Snapshot taken at acceptance; CP0 changes afterwards must not leak in.
    op_e               snap_op_q, snap_op_d;
    logic [31:0]       snap_pc_q, snap_pc_d;
    logic [18:0]       snap_vpn2_q, snap_vpn2_d;
    logic [7:0]        snap_asid_q, snap_asid_d;
    logic [25:0]       snap_lo0_q, snap_lo0_d;
    logic [25:0]       snap_lo1_q, snap_lo1_d;
    logic [IdxW-1:0]   snap_index_q, snap_index_d;

    // Search result captured at the end of SRCH, presented during PWB.
    logic              srch_found_q, srch_found_d;
    logic [IdxW-1:0]   srch_index_q, srch_index_d;

    logic              accept;

    assign accept = (state_q == StIdle) && bus.req_valid && (bus.req_op != OpNone);

    // Next-state and snapshot/search-result capture.
    always_comb begin
        state_d      = state_q;
        snap_op_d    = snap_op_q;
        snap_pc_d    = snap_pc_q;
        snap_vpn2_d  = snap_vpn2_q;
        snap_asid_d  = snap_asid_q;
        snap_lo0_d   = snap_lo0_q;
        snap_lo1_d   = snap_lo1_q;
        snap_index_d = snap_index_q;
        srch_found_d = srch_found_q;
        srch_index_d = srch_index_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    snap_op_d    = op_e'(bus.req_op);
                    snap_pc_d    = bus.req_pc;
                    snap_vpn2_d  = bus.c0_entryhi[31:13];
                    snap_asid_d  = bus.c0_entryhi[7:0];
                    snap_lo0_d   = bus.c0_entrylo0[25:0];
                    snap_lo1_d   = bus.c0_entrylo1[25:0];
                    snap_index_d = bus.c0_index[IdxW-1:0];
                    case (op_e'(bus.req_op))
                        OpTlbp:  state_d = StSrch;
                        OpTlbr:  state_d = StRead;
                        OpTlbwi: state_d = StWrite;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StSrch: begin
                srch_found_d = bus.s_found;
                srch_index_d = bus.s_index;
                state_d      = StPwb;
            end
            StPwb:     state_d = StIdle;
            StRead:    state_d = StRefetch;
            StWrite:   state_d = StRefetch;
            StRefetch: begin
                if (bus.refetch_ready) begin
                    state_d = StIdle;
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    // Single state register for the FSM, snapshot and search result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            snap_op_q    <= OpNone;
            snap_pc_q    <= '0;
            snap_vpn2_q  <= '0;
            snap_asid_q  <= '0;
            snap_lo0_q   <= '0;
            snap_lo1_q   <= '0;
            snap_index_q <= '0;
            srch_found_q <= 1'b0;
            srch_index_q <= '0;
        end else begin
            state_q      <= state_d;
            snap_op_q    <= snap_op_d;
            snap_pc_q    <= snap_pc_d;
            snap_vpn2_q  <= snap_vpn2_d;
            snap_asid_q  <= snap_asid_d;
            snap_lo0_q   <= snap_lo0_d;
            snap_lo1_q   <= snap_lo1_d;
            snap_index_q <= snap_index_d;
            srch_found_q <= srch_found_d;
            srch_index_q <= srch_index_d;
        end
    end

    // Moore outputs: decoded from registered state and snapshot only, so each
    // port is zero outside its own state and pulses last exactly one state.
    always_comb begin
        bus.req_ready     = (state_q == StIdle) && resetn;
        bus.busy          = (state_q != StIdle);
        bus.s_vpn2        = '0;
        bus.s_asid        = '0;
        bus.r_index       = '0;
        bus.w_we          = 1'b0;
        bus.w_index       = '0;
        bus.w_vpn2        = '0;
        bus.w_asid        = '0;
        bus.w_g           = 1'b0;
        bus.w_pfn0        = '0;
        bus.w_pfn1        = '0;
        bus.w_c0          = '0;
        bus.w_c1          = '0;
        bus.w_d0          = 1'b0;
        bus.w_d1          = 1'b0;
        bus.w_v0          = 1'b0;
        bus.w_v1          = 1'b0;
        bus.tlbp          = 1'b0;
        bus.tlbp_found    = 1'b0;
        bus.tlbp_index    = '0;
        bus.tlbr          = 1'b0;
        bus.refetch_valid = 1'b0;
        bus.refetch_pc    = '0;

        case (state_q)
            StSrch: begin
                bus.s_vpn2 = snap_vpn2_q;
                bus.s_asid = snap_asid_q;
            end
            StPwb: begin
                bus.tlbp       = 1'b1;
                bus.tlbp_found = srch_found_q;
                bus.tlbp_index = srch_index_q;
            end
            StRead: begin
                bus.r_index = snap_index_q;
                bus.tlbr    = 1'b1;
            end
            StWrite: begin
                // EntryLo: PFN[25:6], C[5:3], D[2], V[1], G[0]
                bus.w_we    = 1'b1;
                bus.w_index = snap_index_q;
                bus.w_vpn2  = snap_vpn2_q;
                bus.w_asid  = snap_asid_q;
                bus.w_g     = snap_lo0_q[0] & snap_lo1_q[0];
                bus.w_pfn0  = snap_lo0_q[25:6];
                bus.w_pfn1  = snap_lo1_q[25:6];
                bus.w_c0    = snap_lo0_q[5:3];
                bus.w_c1    = snap_lo1_q[5:3];
                bus.w_d0    = snap_lo0_q[2];
                bus.w_d1    = snap_lo1_q[2];
                bus.w_v0    = snap_lo0_q[1];
                bus.w_v1    = snap_lo1_q[1];
            end
            StRefetch: begin
                bus.refetch_valid = 1'b1;
                bus.refetch_pc    = snap_pc_q + 32'd4;
            end
            default: ;
        endcase
    end

    // CP0 bits outside the snapshot fields, and the latched op, are not needed
    // to sequence the operation.
    logic unused_bits;
    assign unused_bits = ^{bus.c0_entryhi[12:8], bus.c0_entrylo0[31:26],
                           bus.c0_entrylo1[31:26], bus.c0_index[31:IdxW], snap_op_q};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: each task drives one scenario and checks the
// outputs at the falling edge against hand-computed values.
module tb_tlb_op_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    tlb_op_ctrl_if #(.IDXW(4)) bus();

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic init_inputs;
        bus.req_valid     = 1'b0;
        bus.req_op        = 2'b00;
        bus.req_pc        = 32'h0;
        bus.c0_entryhi    = 32'h0;
        bus.c0_entrylo0   = 32'h0;
        bus.c0_entrylo1   = 32'h0;
        bus.c0_index      = 32'h0;
        bus.s_found       = 1'b0;
        bus.s_index       = 4'h0;
        bus.refetch_ready = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle T; returns just after the edge
    // ending T, i.e. at the start of T+1.
    task automatic do_accept(input logic [1:0] op, input logic [31:0] pc);
        bus.req_op    = op;
        bus.req_pc    = pc;
        bus.req_valid = 1'b1;
        next_cycle();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
    endtask

    task automatic test_reset;
        init_inputs();
        resetn = 1'b0;
        #3;
        total++;
        if ({bus.busy, bus.w_we, bus.tlbp, bus.tlbr, bus.refetch_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_pulses: got %b want 00000",
                     {bus.busy, bus.w_we, bus.tlbp, bus.tlbr, bus.refetch_valid});
        end
        total++;
        if ({bus.s_vpn2, bus.r_index, bus.w_index, bus.refetch_pc} !== 59'h0) begin
            bad++;
            $display("FAIL reset_buses: got %h want 0",
                     {bus.s_vpn2, bus.r_index, bus.w_index, bus.refetch_pc});
        end
        @(negedge clk);
        resetn = 1'b1;
        next_cycle();
        total++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_idle: got %b want 10", {bus.req_ready, bus.busy});
        end
    endtask

    task automatic test_tlbp_hit;
        bus.c0_entryhi = 32'h0040_2005;
        do_accept(2'b01, 32'h8000_0000);
        bus.c0_entryhi = 32'hFFFF_FFFF;
        bus.s_found    = 1'b1;
        bus.s_index    = 4'd7;
        @(negedge clk);
        total++;
        if ({bus.s_vpn2, bus.s_asid} !== {19'h00201, 8'h05}) begin
            bad++;
            $display("FAIL tlbp_hit_search: got %h/%h want 00201/05", bus.s_vpn2, bus.s_asid);
        end
        total++;
        if ({bus.tlbp, bus.busy, bus.req_ready} !== 3'b010) begin
            bad++;
            $display("FAIL tlbp_hit_t1_ctrl: got %b want 010", {bus.tlbp, bus.busy, bus.req_ready});
        end
        next_cycle();
        bus.s_found = 1'b0;
        bus.s_index = 4'd0;
        @(negedge clk);
        total++;
        if ({bus.tlbp, bus.tlbp_found, bus.tlbp_index} !== 6'b1_1_0111) begin
            bad++;
            $display("FAIL tlbp_hit_pulse: got %b want 110111",
                     {bus.tlbp, bus.tlbp_found, bus.tlbp_index});
        end
        total++;
        if ({bus.refetch_valid, bus.s_vpn2, bus.busy} !== {1'b0, 19'h0, 1'b1}) begin
            bad++;
            $display("FAIL tlbp_hit_t2_misc: got %b/%h/%b want 0/00000/1",
                     bus.refetch_valid, bus.s_vpn2, bus.busy);
        end
        next_cycle();
        total++;
        if ({bus.tlbp, bus.busy, bus.req_ready, bus.refetch_valid} !== 4'b0010) begin
            bad++;
            $display("FAIL tlbp_hit_done: got %b want 0010",
                     {bus.tlbp, bus.busy, bus.req_ready, bus.refetch_valid});
        end
    endtask

    task automatic test_tlbp_miss;
        bus.c0_entryhi = 32'h1234_5678;
        do_accept(2'b01, 32'h0000_2000);
        bus.s_found = 1'b0;
        bus.s_index = 4'hA;
        @(negedge clk);
        total++;
        if ({bus.s_vpn2, bus.s_asid} !== {19'h091A2, 8'h78}) begin
            bad++;
            $display("FAIL tlbp_miss_search: got %h/%h want 091a2/78", bus.s_vpn2, bus.s_asid);
        end
        next_cycle();
        bus.s_found = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.tlbp, bus.tlbp_found} !== 2'b10) begin
            bad++;
            $display("FAIL tlbp_miss_pulse: got %b want 10", {bus.tlbp, bus.tlbp_found});
        end
        next_cycle();
        bus.s_found = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.tlbp, bus.refetch_valid, bus.req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL tlbp_miss_one_cycle: got %b want 001",
                     {bus.tlbp, bus.refetch_valid, bus.req_ready});
        end
    endtask

    task automatic test_tlbr;
        bus.c0_index      = 32'd3;
        bus.refetch_ready = 1'b1;
        do_accept(2'b10, 32'hBFC0_0100);
        bus.c0_index = 32'd9;
        @(negedge clk);
        total++;
        if (bus.r_index !== 4'd3) begin
            bad++;
            $display("FAIL tlbr_index: got %h want 3", bus.r_index);
        end
        total++;
        if ({bus.tlbr, bus.w_we, bus.refetch_valid, bus.tlbp} !== 4'b1000) begin
            bad++;
            $display("FAIL tlbr_pulse: got %b want 1000",
                     {bus.tlbr, bus.w_we, bus.refetch_valid, bus.tlbp});
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({bus.refetch_valid, bus.refetch_pc} !== {1'b1, 32'hBFC0_0104}) begin
            bad++;
            $display("FAIL tlbr_refetch: got %b/%h want 1/bfc00104",
                     bus.refetch_valid, bus.refetch_pc);
        end
        total++;
        if ({bus.tlbr, bus.r_index} !== 5'b0) begin
            bad++;
            $display("FAIL tlbr_one_cycle: got %b want 00000", {bus.tlbr, bus.r_index});
        end
        next_cycle();
        total++;
        if ({bus.refetch_valid, bus.busy, bus.req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL tlbr_done: got %b want 001",
                     {bus.refetch_valid, bus.busy, bus.req_ready});
        end
        bus.refetch_ready = 1'b0;
    endtask

    task automatic test_tlbwi;
        bus.c0_index      = 32'h0000_000F;
        bus.c0_entrylo0   = 32'h0000_0047;
        bus.c0_entrylo1   = 32'h0000_0046;
        bus.c0_entryhi    = 32'h0040_2005;
        bus.refetch_ready = 1'b0;
        do_accept(2'b11, 32'hFFFF_FFFC);
        bus.c0_index    = 32'd2;
        bus.c0_entrylo0 = 32'h0;
        bus.c0_entrylo1 = 32'hFFFF_FFFF;
        bus.c0_entryhi  = 32'h0;
        @(negedge clk);
        total++;
        if ({bus.w_we, bus.w_index, bus.w_g} !== {1'b1, 4'hF, 1'b0}) begin
            bad++;
            $display("FAIL tlbwi_we_index_g: got %b/%h/%b want 1/f/0",
                     bus.w_we, bus.w_index, bus.w_g);
        end
        total++;
        if ({bus.w_pfn0, bus.w_c0, bus.w_pfn1, bus.w_c1} !== {20'd1, 3'd0, 20'd1, 3'd0}) begin
            bad++;
            $display("FAIL tlbwi_pfn_c: got %h/%h/%h/%h want 00001/0/00001/0",
                     bus.w_pfn0, bus.w_c0, bus.w_pfn1, bus.w_c1);
        end
        total++;
        if ({bus.w_d0, bus.w_v0, bus.w_d1, bus.w_v1} !== 4'b1111) begin
            bad++;
            $display("FAIL tlbwi_dv: got %b want 1111", {bus.w_d0, bus.w_v0, bus.w_d1, bus.w_v1});
        end
        total++;
        if ({bus.w_vpn2, bus.w_asid, bus.refetch_valid} !== {19'h00201, 8'h05, 1'b0}) begin
            bad++;
            $display("FAIL tlbwi_hi: got %h/%h/%b want 00201/05/0",
                     bus.w_vpn2, bus.w_asid, bus.refetch_valid);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({bus.refetch_valid, bus.refetch_pc} !== {1'b1, 32'h0000_0000}) begin
            bad++;
            $display("FAIL tlbwi_refetch_wrap: got %b/%h want 1/00000000",
                     bus.refetch_valid, bus.refetch_pc);
        end
        total++;
        if ({bus.w_we, bus.w_index, bus.w_pfn0} !== 25'h0) begin
            bad++;
            $display("FAIL tlbwi_one_cycle: got %b/%h/%h want 0/0/00000",
                     bus.w_we, bus.w_index, bus.w_pfn0);
        end
        bus.refetch_ready = 1'b1;
        next_cycle();
        total++;
        if ({bus.busy, bus.req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL tlbwi_done: got %b want 01", {bus.busy, bus.req_ready});
        end
        bus.refetch_ready = 1'b0;
    endtask

    task automatic test_refetch_backpressure;
        bus.c0_index      = 32'd5;
        bus.c0_entryhi    = 32'h0040_2005;
        bus.refetch_ready = 1'b0;
        do_accept(2'b10, 32'h0000_1000);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 2'b01;
            @(negedge clk);
            total++;
            if ({bus.refetch_valid, bus.refetch_pc, bus.busy, bus.req_ready}
                    !== {1'b1, 32'h0000_1004, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: got %b/%h/%b/%b want 1/00001004/1/0", i,
                         bus.refetch_valid, bus.refetch_pc, bus.busy, bus.req_ready);
            end
            next_cycle();
        end
        bus.req_valid     = 1'b0;
        bus.req_op        = 2'b00;
        total++;
        if ({bus.s_vpn2, bus.tlbp} !== 20'h0) begin
            bad++;
            $display("FAIL backpressure_no_accept: got %h/%b want 00000/0", bus.s_vpn2, bus.tlbp);
        end
        bus.refetch_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.refetch_valid !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_last: got %b want 1", bus.refetch_valid);
        end
        next_cycle();
        total++;
        if ({bus.refetch_valid, bus.busy, bus.req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL backpressure_release: got %b want 001",
                     {bus.refetch_valid, bus.busy, bus.req_ready});
        end
        bus.refetch_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int we_pulses = 0;
        bus.c0_index      = 32'd6;
        bus.c0_entrylo0   = 32'h0000_0041;
        bus.c0_entrylo1   = 32'h0000_0041;
        bus.c0_entryhi    = 32'h0040_2005;
        bus.refetch_ready = 1'b1;
        do_accept(2'b11, 32'h0000_0100);
        // WB presents the next TLBP immediately and holds it.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        @(negedge clk);
        if (bus.w_we === 1'b1) we_pulses++;
        total++;
        if ({bus.w_we, bus.w_g, bus.req_ready} !== 3'b110) begin
            bad++;
            $display("FAIL b2b_write: got %b want 110", {bus.w_we, bus.w_g, bus.req_ready});
        end
        next_cycle();
        @(negedge clk);
        if (bus.w_we === 1'b1) we_pulses++;
        total++;
        if ({bus.refetch_valid, bus.req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_refetch: got %b want 10", {bus.refetch_valid, bus.req_ready});
        end
        next_cycle();
        @(negedge clk);
        if (bus.w_we === 1'b1) we_pulses++;
        total++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_idle: got %b want 10", {bus.req_ready, bus.busy});
        end
        next_cycle();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.s_found   = 1'b1;
        bus.s_index   = 4'd2;
        @(negedge clk);
        if (bus.w_we === 1'b1) we_pulses++;
        total++;
        if ({bus.busy, bus.s_vpn2} !== {1'b1, 19'h00201}) begin
            bad++;
            $display("FAIL b2b_second_search: got %b/%h want 1/00201", bus.busy, bus.s_vpn2);
        end
        next_cycle();
        bus.s_found = 1'b0;
        @(negedge clk);
        if (bus.w_we === 1'b1) we_pulses++;
        total++;
        if ({bus.tlbp, bus.tlbp_found, bus.tlbp_index} !== 6'b1_1_0010) begin
            bad++;
            $display("FAIL b2b_second_pulse: got %b want 110010",
                     {bus.tlbp, bus.tlbp_found, bus.tlbp_index});
        end
        total++;
        if (we_pulses !== 1) begin
            bad++;
            $display("FAIL b2b_we_count: got %0d want 1", we_pulses);
        end
        next_cycle();
        bus.refetch_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        bus.c0_index      = 32'd4;
        bus.refetch_ready = 1'b0;
        do_accept(2'b11, 32'h0000_0200);
        // In WRITE, before the edge that would end it.
        resetn = 1'b0;
        #1;
        total++;
        if ({bus.w_we, bus.refetch_valid, bus.busy, bus.w_index} !== 7'b0) begin
            bad++;
            $display("FAIL reset_mid_clear: got %b want 0000000",
                     {bus.w_we, bus.refetch_valid, bus.busy, bus.w_index});
        end
        @(negedge clk);
        resetn = 1'b1;
        next_cycle();
        total++;
        if ({bus.w_we, bus.refetch_valid, bus.busy, bus.req_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_idle: got %b want 0001",
                     {bus.w_we, bus.refetch_valid, bus.busy, bus.req_ready});
        end
        next_cycle();
        total++;
        if ({bus.w_we, bus.refetch_valid, bus.tlbr, bus.req_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_no_leak: got %b want 0001",
                     {bus.w_we, bus.refetch_valid, bus.tlbr, bus.req_ready});
        end
    endtask

    initial begin
        test_reset();
        test_tlbp_hit();
        test_tlbp_miss();
        test_tlbr();
        test_tlbwi();
        test_refetch_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
